// File: rtl/alu_pkg.sv
// Shared types for the ALU sequencing stage: opcodes, flag indices, FSM states.
// Optional build macro: ALU_EXEC_CTRL_BYPASS_EN (same-cycle load forwarding).
package alu_pkg;

  localparam int BW   = 16;
  localparam int NREG = 8;

  typedef enum logic [2:0] {
    OP_ADD   = 3'b000,
    OP_SUB   = 3'b001,
    OP_AND   = 3'b010,
    OP_OR    = 3'b011,
    OP_XOR   = 3'b100,
    OP_INC   = 3'b101,
    OP_PASSA = 3'b110,
    OP_PASSB = 3'b111
  } op_e;

  localparam int FLAG_OV  = 2;
  localparam int FLAG_NEG = 1;
  localparam int FLAG_Z   = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_EXEC = 2'b01,
    S_WB   = 2'b10
  } state_e;

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Instruction handshake bundle between an issuing source and alu_exec_ctrl.
// master = issuing source, slave = alu_exec_ctrl.
interface alu_exec_ctrl_if #(
  parameter int AW = 3
) ();

  logic          instr_valid;
  logic          instr_ready;
  logic [2:0]    instr_opcode;
  logic [AW-1:0] instr_dst;
  logic [AW-1:0] instr_src_a;
  logic [AW-1:0] instr_src_b;

  modport master (
    output instr_valid,
    output instr_opcode,
    output instr_dst,
    output instr_src_a,
    output instr_src_b,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_opcode,
    input  instr_dst,
    input  instr_src_a,
    input  instr_src_b,
    output instr_ready
  );

endinterface

// File: rtl/alu_regfile.sv
// NREG x BW register file: one write port, three combinational reads.
// R0 reads as zero and ignores writes.
module alu_regfile #(
  parameter int BW   = 16,
  parameter int NREG = 8,
  parameter int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [BW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [BW-1:0] rdata_b,
  input  logic [AW-1:0] raddr_c,
  output logic [BW-1:0] rdata_c
);

  logic [BW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
  assign rdata_c = (raddr_c == '0) ? '0 : mem[raddr_c];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Serialized IDLE->EXEC->WB sequencer around an external combinational ALU.
// ALU_EXEC_CTRL_BYPASS_EN: forward a same-cycle load into operand capture.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter  int BW   = 16,
  parameter  int NREG = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  alu_exec_ctrl_if.slave instr,
  input  logic           load_en,
  input  logic [AW-1:0]  load_addr,
  input  logic [BW-1:0]  load_data,
  output logic [BW-1:0]  alu_a,
  output logic [BW-1:0]  alu_b,
  output logic [2:0]     alu_opcode,
  input  logic [BW-1:0]  alu_out,
  input  logic [2:0]     alu_flags,
  output logic [2:0]     flags_q,
  output logic           done,
  input  logic [AW-1:0]  rd_addr,
  output logic [BW-1:0]  rd_data
);

  state_e        state;
  logic [BW-1:0] op_a;
  logic [BW-1:0] op_b;
  op_e           opcode_q;
  logic [AW-1:0] dst_q;
  logic [BW-1:0] result_q;
  logic [2:0]    flags_r;
  logic          done_r;
  logic          ready_r;

  logic          idle;
  logic          ld;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [BW-1:0] rf_wdata;
  logic [BW-1:0] rf_a;
  logic [BW-1:0] rf_b;
  logic [BW-1:0] cap_a;
  logic [BW-1:0] cap_b;

  assign idle = (state == S_IDLE);
  assign ld   = idle && load_en;

  // Loads only land in IDLE and write-back only in WB, so they never collide.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = load_addr;
    rf_wdata = load_data;
    unique case (1'b1)
      (state == S_WB): begin
        rf_we    = 1'b1;
        rf_waddr = dst_q;
        rf_wdata = result_q;
      end
      ld: begin
        rf_we    = 1'b1;
      end
      default: ;
    endcase
  end

  alu_regfile #(
    .BW   (BW),
    .NREG (NREG),
    .AW   (AW)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (instr.instr_src_a),
    .rdata_a (rf_a),
    .raddr_b (instr.instr_src_b),
    .rdata_b (rf_b),
    .raddr_c (rd_addr),
    .rdata_c (rd_data)
  );

`ifdef ALU_EXEC_CTRL_BYPASS_EN
  assign cap_a = (ld && (load_addr != '0) &&
                  (load_addr == instr.instr_src_a)) ? load_data : rf_a;
  assign cap_b = (ld && (load_addr != '0) &&
                  (load_addr == instr.instr_src_b)) ? load_data : rf_b;
`else
  assign cap_a = rf_a;
  assign cap_b = rf_b;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ready_r  <= 1'b1;
      done_r   <= 1'b0;
      flags_r  <= '0;
      op_a     <= '0;
      op_b     <= '0;
      opcode_q <= OP_ADD;
      dst_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done_r <= 1'b0;
          if (instr.instr_valid) begin
            op_a     <= cap_a;
            op_b     <= cap_b;
            opcode_q <= op_e'(instr.instr_opcode);
            dst_q    <= instr.instr_dst;
            ready_r  <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= alu_out;
          flags_r  <= alu_flags;
          done_r   <= 1'b1;
          state    <= S_WB;
        end
        S_WB: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= S_IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          ready_r <= 1'b1;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign instr.instr_ready = ready_r;
  assign alu_a             = op_a;
  assign alu_b             = op_b;
  assign alu_opcode        = opcode_q;
  assign flags_q           = flags_r;
  assign done              = done_r;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Randomized + directed bench for alu_exec_ctrl with a behavioural ALU
// and a register-array reference model.
`timescale 1ns/1ps
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  localparam int TB_BW = 16;
  localparam int TB_NR = 8;
  localparam int TB_AW = 3;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  alu_exec_ctrl_if #(.AW(TB_AW)) instr ();

  logic             load_en;
  logic [TB_AW-1:0] load_addr;
  logic [TB_BW-1:0] load_data;
  logic [TB_BW-1:0] alu_a;
  logic [TB_BW-1:0] alu_b;
  logic [2:0]       alu_opcode;
  logic [TB_BW-1:0] alu_out;
  logic [2:0]       alu_flags;
  logic [2:0]       flags_q;
  logic             done;
  logic [TB_AW-1:0] rd_addr;
  logic [TB_BW-1:0] rd_data;

  alu_exec_ctrl #(.BW(TB_BW), .NREG(TB_NR)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (instr),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .flags_q    (flags_q),
    .done       (done),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  // returns {ov, neg, zero, result}
  function automatic logic [TB_BW+2:0] alu_calc(
    input logic [2:0] op, input logic [TB_BW-1:0] a, input logic [TB_BW-1:0] b);
    logic [TB_BW-1:0] r;
    logic ov;
    r  = '0;
    ov = 1'b0;
    case (op)
      3'd0: begin r = a + b; ov = (a[TB_BW-1] == b[TB_BW-1]) && (r[TB_BW-1] != a[TB_BW-1]); end
      3'd1: begin r = a - b; ov = (a[TB_BW-1] != b[TB_BW-1]) && (r[TB_BW-1] != a[TB_BW-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin r = a + 1'b1; ov = (a == 16'h7FFF); end
      3'd6: r = a;
      default: r = b;
    endcase
    return {ov, r[TB_BW-1], (r == '0), r};
  endfunction

  always_comb {alu_flags, alu_out} = alu_calc(alu_opcode, alu_a, alu_b);

  logic [TB_BW-1:0] m_reg [TB_NR];
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_check(input string tag, input int a, input logic [TB_BW-1:0] exp);
    rd_addr = a[TB_AW-1:0];
    #1;
    check(tag, {16'h0, rd_data}, {16'h0, exp});
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < TB_NR; i++) rd_check(tag, i, m_reg[i]);
  endtask

  task automatic model_clear();
    for (int i = 0; i < TB_NR; i++) m_reg[i] = '0;
  endtask

  task automatic load(input int a, input logic [TB_BW-1:0] d);
    load_en   = 1'b1;
    load_addr = a[TB_AW-1:0];
    load_data = d;
    tick();
    load_en = 1'b0;
    if (a != 0) m_reg[a] = d;
  endtask

  task automatic do_instr(input logic [2:0] op, input int dst, input int sa, input int sb,
                          input logic le, input int la, input logic [TB_BW-1:0] ld);
    logic [TB_BW-1:0] a;
    logic [TB_BW-1:0] b;
    logic [TB_BW+2:0] res;
    check("ready_idle", {31'h0, instr.instr_ready}, 32'd1);
    instr.instr_valid  = 1'b1;
    instr.instr_opcode = op;
    instr.instr_dst    = dst[TB_AW-1:0];
    instr.instr_src_a  = sa[TB_AW-1:0];
    instr.instr_src_b  = sb[TB_AW-1:0];
    load_en   = le;
    load_addr = la[TB_AW-1:0];
    load_data = ld;
    a = m_reg[sa];
    b = m_reg[sb];
`ifdef ALU_EXEC_CTRL_BYPASS_EN
    if (le && la != 0 && la == sa) a = ld;
    if (le && la != 0 && la == sb) b = ld;
`endif
    if (le && la != 0) m_reg[la] = ld;
    res = alu_calc(op, a, b);
    tick();
    instr.instr_valid = 1'b0;
    load_en = 1'b0;
    check("ready_exec", {31'h0, instr.instr_ready}, 32'd0);
    check("done_exec", {31'h0, done}, 32'd0);
    tick();
    check("done_wb", {31'h0, done}, 32'd1);
    check("flags_wb", {29'h0, flags_q}, {29'h0, res[TB_BW+2:TB_BW]});
    tick();
    check("done_clr", {31'h0, done}, 32'd0);
    check("ready_back", {31'h0, instr.instr_ready}, 32'd1);
    if (dst != 0) m_reg[dst] = res[TB_BW-1:0];
    check_regs("regs");
  endtask

  initial begin
    logic [TB_BW-1:0] pat [4];
    pat[0] = 16'h7FFF; pat[1] = 16'h8000; pat[2] = 16'hFFFF; pat[3] = 16'h0001;
    rst = 1'b1;
    instr.instr_valid = 1'b0;
    instr.instr_opcode = '0;
    instr.instr_dst = '0;
    instr.instr_src_a = '0;
    instr.instr_src_b = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0; rd_addr = '0;
    model_clear();
    tick(); tick();
    rst = 1'b0;
    check("rst_ready", {31'h0, instr.instr_ready}, 32'd1);
    check("rst_flags", {29'h0, flags_q}, 32'd0);
    check("rst_done", {31'h0, done}, 32'd0);
    check_regs("rst_regs");

    load(1, 16'd100); load(2, 16'd200);
    do_instr(OP_ADD, 3, 1, 2, 1'b0, 0, '0);
    rd_check("add_r3", 3, 16'd300);
    check("add_flags", {29'h0, flags_q}, 32'd0);

    load(1, 16'h7FFF); load(2, 16'h0001);
    do_instr(OP_ADD, 4, 1, 2, 1'b0, 0, '0);
    rd_check("ov_r4", 4, 16'h8000);
    check("ov_flags", {29'h0, flags_q}, 32'b110);
    do_instr(OP_SUB, 5, 1, 1, 1'b0, 0, '0);
    rd_check("sub_r5", 5, 16'h0000);
    check("sub_flags", {29'h0, flags_q}, 32'b001);

    load(1, 16'd100); load(2, 16'd200);
    do_instr(OP_ADD, 0, 1, 2, 1'b0, 0, '0);
    rd_check("r0_wb", 0, 16'h0000);
    check("r0_flags", {29'h0, flags_q}, 32'd0);

    // valid held across the busy window; load during EXEC is dropped
    instr.instr_valid = 1'b1;
    instr.instr_opcode = OP_ADD;
    instr.instr_dst = 3'd3; instr.instr_src_a = 3'd1; instr.instr_src_b = 3'd2;
    tick();
    instr.instr_src_a = 3'd3; instr.instr_src_b = 3'd3;
    load_en = 1'b1; load_addr = 3'd6; load_data = 16'h1234;
    tick();
    load_en = 1'b0;
    check("b2b_done1", {31'h0, done}, 32'd1);
    check("b2b_busy", {31'h0, instr.instr_ready}, 32'd0);
    tick();
    check("b2b_idle", {31'h0, instr.instr_ready}, 32'd1);
    rd_check("b2b_r3a", 3, 16'd300);
    tick();
    instr.instr_valid = 1'b0;
    check("b2b_exec", {31'h0, done}, 32'd0);
    tick();
    check("b2b_done2", {31'h0, done}, 32'd1);
    tick();
    m_reg[3] = 16'd600;
    rd_check("b2b_r3b", 3, 16'd600);
    rd_check("b2b_r6", 6, 16'h0000);
    check_regs("b2b_regs");

    // reset while in EXEC
    instr.instr_valid = 1'b1;
    instr.instr_opcode = OP_ADD;
    instr.instr_dst = 3'd5; instr.instr_src_a = 3'd3; instr.instr_src_b = 3'd3;
    tick();
    instr.instr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check("mid_ready", {31'h0, instr.instr_ready}, 32'd1);
    check("mid_done", {31'h0, done}, 32'd0);
    check("mid_flags", {29'h0, flags_q}, 32'd0);
    check_regs("mid_regs");
    tick();
    check("mid_nodone", {31'h0, done}, 32'd0);

    do_instr(OP_ADD, 2, 1, 1, 1'b1, 1, 16'd5);
`ifdef ALU_EXEC_CTRL_BYPASS_EN
    rd_check("same_cyc", 2, 16'd10);
`else
    rd_check("same_cyc", 2, 16'd0);
`endif
    rd_check("same_r1", 1, 16'd5);

    for (int n = 0; n < 60; n++) begin
      logic [TB_BW-1:0] d;
      d = ($urandom_range(3) == 0) ? pat[$urandom_range(3)] : TB_BW'($urandom);
      if ($urandom_range(2) == 0) load($urandom_range(TB_NR - 1), d);
      d = ($urandom_range(3) == 0) ? pat[$urandom_range(3)] : TB_BW'($urandom);
      do_instr(3'($urandom_range(7)), $urandom_range(TB_NR - 1),
               $urandom_range(TB_NR - 1), $urandom_range(TB_NR - 1),
               ($urandom_range(3) == 0), $urandom_range(TB_NR - 1), d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Sequencing stage wrapped around the combinational ALU. It sits both upstream and downstream of the ALU.
- Accepts one instruction per valid/ready handshake and reads two operands from an internal register file.
- Drives the ALU (in_a, in_b, opcode), captures its out/flags, and writes the result back to the register file.
- Holds the architectural flag register consumed by later branch logic.

Parameters:
- BW, 16, data width; must match the ALU BW.
- NREG, 8, register count (power of 2); AW = $clog2(NREG).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr_opcode  in  3  ALU opcode
- instr_dst  in  AW  destination register
- instr_src_a  in  AW  operand A register
- instr_src_b  in  AW  operand B register
- load_en  in  1  direct register write (immediate load)
- load_addr  in  AW  load target
- load_data  in  BW  load value (signed)
- alu_a  out  BW  to ALU in_a
- alu_b  out  BW  to ALU in_b
- alu_opcode  out  3  to ALU opcode
- alu_out  in  BW  from ALU out
- alu_flags  in  3  from ALU flags {overflow, negative, zero}
- flags_q  out  3  registered flags {overflow, negative, zero}
- done  out  1  one-cycle pulse on write-back
- rd_addr  in  AW  debug read address
- rd_data  out  BW  debug read data, combinational

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - All registers 0.
  - State IDLE; instr_ready=1.
  - flags_q=000; done=0.
  - alu_a/alu_b/alu_opcode=0.
- R0 is hardwired zero: reads return 0; writes (load or write-back) are discarded.
- FSM IDLE -> EXEC -> WB -> IDLE:
  - IDLE:
    - instr_ready=1.
    - On instr_valid: register op_a=R[src_a], op_b=R[src_b], opcode and dst; go to EXEC.
    - Operands are read from pre-edge register contents.
  - EXEC:
    - instr_ready=0.
    - alu_a/alu_b/alu_opcode driven from registered op_a/op_b/opcode.
    - At the edge: result_q <= alu_out and flags_q <= alu_flags; go to WB.
  - WB:
    - instr_ready=0; R[dst] <= result_q; done=1 for this cycle only; go to IDLE.
- Latency: accept edge at cycle 0, done high in cycle 2, result readable via rd_data in cycle 3. Throughput: one instruction per 3 cycles.
- Dependency: an instruction accepted in the cycle after done sees the written value. No hazards exist because operations are strictly serialized.
- flags_q updates in every EXEC, for all 8 opcodes, including when dst=R0. It holds its value otherwise.
- The result is taken unmodified from the ALU; overflow wraps mod 2^BW. The block never recomputes flags.
- load_en is honoured only in IDLE and ignored in EXEC/WB; there is no queueing.
  - load_en and instr_valid in the same IDLE cycle: the load is performed and the instruction is accepted. Operand read behaviour depends on the optional feature.
- instr_valid held while the block is busy: the instruction is not accepted until the next IDLE. The source must keep fields stable while valid && !ready.
- rst in any state: next cycle IDLE, no done pulse, the in-flight result is discarded, registers and flags cleared.

Optional Feature:
- Macro: ALU_EXEC_CTRL_BYPASS_EN.
- Defined: a same-cycle load forwards to the operand capture. If load_en && instr_valid in IDLE and load_addr==src_a (or src_b) and load_addr!=0, the op register takes load_data.
- Undefined: the operand captures the pre-load register value.

Decomposition:
- Package alu_pkg:
  - BW default constant.
  - Opcode enum: OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_INC=101, OP_PASSA=110, OP_PASSB=111.
  - Flag index constants: FLAG_OV=2, FLAG_NEG=1, FLAG_Z=0.
  - FSM state enum.
- Sub-module alu_regfile: NREG x BW, one write port, three combinational read ports (src_a, src_b, rd_addr), R0 forced to zero.
- The write mux (load vs write-back) lives in alu_exec_ctrl.

Test Plan:
- Reset: rst for 2 cycles -> instr_ready=1, flags_q=000, rd_data=0 for all addresses, done=0.
- Basic ADD: load R1=100, R2=200; ADD dst=R3 -> done exactly 2 cycles after accept, R3=300, flags_q=000.
- Overflow: load R1=0x7FFF, R2=1; ADD dst=R4 -> R4=0x8000, flags_q=110. Then SUB R5=R1-R1 -> R5=0, flags_q=001.
- R0 write-back: ADD dst=R0 (R1+R2 = 300) -> R0 stays 0, flags_q=000.
- Back-to-back with valid held high: second ADD R3=R3+R3 accepted only after done -> R3=600. Load during EXEC -> ignored.
- Reset mid-op: rst in EXEC -> next cycle IDLE, no done, all registers 0.
- Same-cycle load and instruction with R1 previously 0: load R1=5 with ADD R2=R1+R1 -> R2=10 with ALU_EXEC_CTRL_BYPASS_EN, R2=0 without.
